alu_chain_ctrl: RTL

Initiator/sequencer for the 4-bit combinational ALU. It accepts a wide operation (NIBBLES x 4 bits), issues it to the ALU one nibble per cycle starting with the LSB nibble, and chains the carry between nibbles for arithmetic ops. It collects R and the flags into a wide result with aggregate carry/zero/sign, reported through a start/busy/done handshake. It sits between a control unit or testbench and one ALU instance.

---
 rtl/alu_chain_ctrl_if.sv | 29 ++
 rtl/alu_chain_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_chain_ctrl_if.sv
// Host-side request/response bundle for alu_chain_ctrl.
// master = control unit / testbench, slave = the sequencer.
interface alu_chain_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   op_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         sign;

  modport master (
    output start, op_in, a_in, b_in, cin_in,
    input  busy, done, result, carry, zero, sign
  );

  modport slave (
    input  start, op_in, a_in, b_in, cin_in,
    output busy, done, result, carry, zero, sign
  );
endinterface

// File: rtl/alu_chain_ctrl.sv
// Nibble-serial sequencer for a 4-bit combinational ALU: issues a wide
// operation LSB nibble first, chains the carry for arithmetic ops and
// assembles the wide result with aggregate carry/zero/sign flags.
module alu_chain_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_chain_ctrl_if.slave host,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_cin,
  output logic [2:0]   alu_op,
  input  logic [3:0]   alu_r,
  input  logic         alu_carry,
  input  logic         alu_zero,
  input  logic         alu_sign
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned WR = W - 4;
  localparam int unsigned IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_op;
  logic          r_cin;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_zacc;
  logic [WR-1:0] r_wres;

  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_zero;
  logic          r_sign;

  logic          w_busy;
  logic          w_done;
  logic          w_run;
  logic          w_last;
  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;

  assign w_last = (r_idx == IW'(NIBBLES - 1));

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (host.start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_run  = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Select the current operand nibbles from the latched operands.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_nib = r_a[4*k +: 4];
        w_b_nib = r_b[4*k +: 4];
      end
    end
  end

  // Operand latch, per-nibble accumulation and final result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cin    <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_wres   <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_sign   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (host.start) begin
            r_a     <= host.a_in;
            r_b     <= host.b_in;
            r_op    <= host.op_in;
            r_cin   <= host.cin_in;
            r_idx   <= '0;
            r_carry <= host.cin_in;
            r_zacc  <= 1'b1;
          end
        end
        S_RUN: begin
          // The top nibble goes straight into the result, so only the
          // lower NIBBLES-1 nibbles need a working slot.
          for (int unsigned k = 0; k < NIBBLES - 1; k++) begin
            if (r_idx == IW'(k)) begin
              r_wres[4*k +: 4] <= alu_r;
            end
          end
          r_zacc <= r_zacc & alu_zero;
          if (!r_op[2]) begin
            r_carry <= alu_carry;
          end
          if (w_last) begin
            r_result <= {alu_r, r_wres};
            r_cout   <= ~r_op[2] & alu_carry;
            r_zero   <= r_zacc & alu_zero;
            r_sign   <= alu_sign;
            r_idx    <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_a   = w_run ? w_a_nib : '0;
  assign alu_b   = w_run ? w_b_nib : '0;
  assign alu_op  = w_run ? r_op    : '0;
  assign alu_cin = w_run ? (r_op[2] ? r_cin : r_carry) : 1'b0;

  assign host.busy   = w_busy;
  assign host.done   = w_done;
  assign host.result = r_result;
  assign host.carry  = r_cout;
  assign host.zero   = r_zero;
  assign host.sign   = r_sign;

endmodule
